rv32e_alu_issue: RTL and testbench



---
 rtl/rv32e_pkg.sv | 21 ++
 rtl/rv32e_alu.sv | 27 ++
 rtl/rv32e_alu_decode.sv | 83 ++++++++
 rtl/rv32e_alu_issue.sv | 147 ++++++++++++++
 tb/tb_rv32e_alu_issue.sv | 368 ++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/rv32e_pkg.sv
// Shared RV32E ALU op codes and OP/OP-IMM opcode/funct7 constants.
package rv32e_pkg;

  localparam logic [3:0] ALU_ADD  = 4'b0000;
  localparam logic [3:0] ALU_SUB  = 4'b0001;
  localparam logic [3:0] ALU_AND  = 4'b0010;
  localparam logic [3:0] ALU_OR   = 4'b0011;
  localparam logic [3:0] ALU_XOR  = 4'b0100;
  localparam logic [3:0] ALU_SLL  = 4'b0101;
  localparam logic [3:0] ALU_SRL  = 4'b0110;
  localparam logic [3:0] ALU_SRA  = 4'b0111;
  localparam logic [3:0] ALU_SLT  = 4'b1000;
  localparam logic [3:0] ALU_SLTU = 4'b1001;

  localparam logic [6:0] OPC_OP    = 7'b0110011;
  localparam logic [6:0] OPC_OPIMM = 7'b0010011;

  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;

endpackage

// File: rtl/rv32e_alu.sv
// Combinational RV32E ALU driven by the issue stage.
module rv32e_alu (
  input  logic [3:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [31:0] result
);
  import rv32e_pkg::*;

  always_comb begin
    result = '0;
    unique case (op)
      ALU_ADD:  result = a + b;
      ALU_SUB:  result = a - b;
      ALU_AND:  result = a & b;
      ALU_OR:   result = a | b;
      ALU_XOR:  result = a ^ b;
      ALU_SLL:  result = a << b[4:0];
      ALU_SRL:  result = a >> b[4:0];
      ALU_SRA:  result = $unsigned($signed(a) >>> b[4:0]);
      ALU_SLT:  result = {31'b0, $signed(a) < $signed(b)};
      ALU_SLTU: result = {31'b0, a < b};
      default:  result = '0;
    endcase
  end

endmodule

// File: rtl/rv32e_alu_decode.sv
// Maps an RV32E OP/OP-IMM word plus register values to ALU op and operands.
module rv32e_alu_decode (
  input  logic [31:0] instr,
  input  logic [31:0] rs1_data,
  input  logic [31:0] rs2_data,
  output logic [3:0]  op,
  output logic [31:0] a,
  output logic [31:0] b,
  output logic [3:0]  rd,
  output logic        illegal
);
  import rv32e_pkg::*;

  logic [6:0]  opc;
  logic [6:0]  f7;
  logic [2:0]  f3;
  logic [4:0]  rd_f;
  logic [4:0]  rs1_f;
  logic [4:0]  rs2_f;
  logic [31:0] imm;
  logic [31:0] shamt;
  logic [3:0]  base_op;
  logic        bad;

  assign opc   = instr[6:0];
  assign rd_f  = instr[11:7];
  assign f3    = instr[14:12];
  assign rs1_f = instr[19:15];
  assign rs2_f = instr[24:20];
  assign f7    = instr[31:25];
  assign imm   = {{20{instr[31]}}, instr[31:20]};
  assign shamt = {27'b0, instr[24:20]};
  assign rd    = rd_f[3:0];

  always_comb begin
    unique case (f3)
      3'b000: base_op = ALU_ADD;
      3'b001: base_op = ALU_SLL;
      3'b010: base_op = ALU_SLT;
      3'b011: base_op = ALU_SLTU;
      3'b100: base_op = ALU_XOR;
      3'b101: base_op = ALU_SRL;
      3'b110: base_op = ALU_OR;
      3'b111: base_op = ALU_AND;
    endcase
  end

  always_comb begin
    op  = base_op;
    a   = rs1_data;
    b   = rs2_data;
    bad = 1'b0;
    unique case (1'b1)
      opc == OPC_OP: begin
        bad = rs2_f[4];
        if (f7 == F7_ALT) begin
          if (f3 == 3'b000)      op  = ALU_SUB;
          else if (f3 == 3'b101) op  = ALU_SRA;
          else                   bad = 1'b1;
        end else if (f7 != F7_BASE) begin
          bad = 1'b1;
        end
      end
      opc == OPC_OPIMM: begin
        b = imm;
        if (f3 == 3'b001 || f3 == 3'b101) begin
          b = shamt;
          if (f7 == F7_ALT && f3 == 3'b101) op  = ALU_SRA;
          else if (f7 != F7_BASE)           bad = 1'b1;
        end
      end
      default: bad = 1'b1;
    endcase
    illegal = bad | rd_f[4] | rs1_f[4];
    // illegal words ride the pipe as a harmless 0+0
    if (illegal) begin
      op = ALU_ADD;
      a  = '0;
      b  = '0;
    end
  end

endmodule

// File: rtl/rv32e_alu_issue.sv
// Two-stage issue/writeback pipe around rv32e_alu with valid/ready
// handshakes, flush and a retired-instruction counter.
module rv32e_alu_issue (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        flush,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_instr,
  input  logic [31:0] in_rs1_data,
  input  logic [31:0] in_rs2_data,
  output logic [3:0]  alu_op,
  output logic [31:0] alu_a,
  output logic [31:0] alu_b,
  input  logic [31:0] alu_result,
  output logic        wb_valid,
  input  logic        wb_ready,
  output logic [3:0]  wb_rd,
  output logic        wb_we,
  output logic [31:0] wb_data,
  output logic        wb_illegal,
  output logic [31:0] retired_cnt
);

  logic [3:0]  dec_op;
  logic [31:0] dec_a;
  logic [31:0] dec_b;
  logic [3:0]  dec_rd;
  logic        dec_ill;

  rv32e_alu_decode u_dec (
    .instr    (in_instr),
    .rs1_data (in_rs1_data),
    .rs2_data (in_rs2_data),
    .op       (dec_op),
    .a        (dec_a),
    .b        (dec_b),
    .rd       (dec_rd),
    .illegal  (dec_ill)
  );

  logic        s1_valid_q, s1_valid_d;
  logic [3:0]  op_q, op_d;
  logic [31:0] a_q, a_d;
  logic [31:0] b_q, b_d;
  logic [3:0]  rd_q, rd_d;
  logic        ill_q, ill_d;
  logic        wb_valid_q, wb_valid_d;
  logic [3:0]  wb_rd_q, wb_rd_d;
  logic        wb_we_q, wb_we_d;
  logic [31:0] wb_data_q, wb_data_d;
  logic        wb_ill_q, wb_ill_d;
  logic [31:0] cnt_q, cnt_d;

  logic s2_free;
  logic s1_adv;
  logic accept;
  logic wb_fire;

  always_comb begin
    s2_free  = !wb_valid_q || wb_ready;
    s1_adv   = s1_valid_q && s2_free;
    in_ready = !s1_valid_q || s2_free;
    accept   = in_valid && in_ready && !flush;
    wb_fire  = wb_valid_q && wb_ready;
  end

  always_comb begin
    s1_valid_d = s1_valid_q;
    op_d       = op_q;
    a_d        = a_q;
    b_d        = b_q;
    rd_d       = rd_q;
    ill_d      = ill_q;
    wb_valid_d = wb_valid_q;
    wb_rd_d    = wb_rd_q;
    wb_we_d    = wb_we_q;
    wb_data_d  = wb_data_q;
    wb_ill_d   = wb_ill_q;
    cnt_d      = cnt_q + {31'b0, wb_fire};
    if (flush) begin
      s1_valid_d = 1'b0;
      wb_valid_d = 1'b0;
    end else begin
      if (accept) begin
        s1_valid_d = 1'b1;
        op_d       = dec_op;
        a_d        = dec_a;
        b_d        = dec_b;
        rd_d       = dec_rd;
        ill_d      = dec_ill;
      end else if (s1_adv) begin
        s1_valid_d = 1'b0;
      end
      if (s1_adv) begin
        wb_valid_d = 1'b1;
        wb_rd_d    = rd_q;
        wb_we_d    = !ill_q && (rd_q != 4'd0);
        wb_data_d  = ill_q ? 32'd0 : alu_result;
        wb_ill_d   = ill_q;
      end else if (wb_fire) begin
        wb_valid_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q <= 1'b0;
      op_q       <= '0;
      a_q        <= '0;
      b_q        <= '0;
      rd_q       <= '0;
      ill_q      <= 1'b0;
      wb_valid_q <= 1'b0;
      wb_rd_q    <= '0;
      wb_we_q    <= 1'b0;
      wb_data_q  <= '0;
      wb_ill_q   <= 1'b0;
      cnt_q      <= '0;
    end else begin
      s1_valid_q <= s1_valid_d;
      op_q       <= op_d;
      a_q        <= a_d;
      b_q        <= b_d;
      rd_q       <= rd_d;
      ill_q      <= ill_d;
      wb_valid_q <= wb_valid_d;
      wb_rd_q    <= wb_rd_d;
      wb_we_q    <= wb_we_d;
      wb_data_q  <= wb_data_d;
      wb_ill_q   <= wb_ill_d;
      cnt_q      <= cnt_d;
    end
  end

  assign alu_op      = op_q;
  assign alu_a       = a_q;
  assign alu_b       = b_q;
  assign wb_valid    = wb_valid_q;
  assign wb_rd       = wb_rd_q;
  assign wb_we       = wb_we_q;
  assign wb_data     = wb_data_q;
  assign wb_illegal  = wb_ill_q;
  assign retired_cnt = cnt_q;

endmodule

// File: tb/tb_rv32e_alu_issue.sv
// Bench for rv32e_alu_issue + rv32e_alu: directed steps then random traffic
// against an in-order queue model of the pipe.
module tb_rv32e_alu_issue;

  logic        clk;
  logic        rst_n;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_instr;
  logic [31:0] in_rs1_data;
  logic [31:0] in_rs2_data;
  logic [3:0]  alu_op;
  logic [31:0] alu_a;
  logic [31:0] alu_b;
  logic [31:0] alu_result;
  logic        wb_valid;
  logic        wb_ready;
  logic [3:0]  wb_rd;
  logic        wb_we;
  logic [31:0] wb_data;
  logic        wb_illegal;
  logic [31:0] retired_cnt;

  rv32e_alu_issue dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .flush       (flush),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_instr    (in_instr),
    .in_rs1_data (in_rs1_data),
    .in_rs2_data (in_rs2_data),
    .alu_op      (alu_op),
    .alu_a       (alu_a),
    .alu_b       (alu_b),
    .alu_result  (alu_result),
    .wb_valid    (wb_valid),
    .wb_ready    (wb_ready),
    .wb_rd       (wb_rd),
    .wb_we       (wb_we),
    .wb_data     (wb_data),
    .wb_illegal  (wb_illegal),
    .retired_cnt (retired_cnt)
  );

  rv32e_alu u_alu (
    .op     (alu_op),
    .a      (alu_a),
    .b      (alu_b),
    .result (alu_result)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  rd;
    logic        we;
    logic [31:0] data;
    logic        ill;
    int          age;
  } ent_t;

  typedef struct {
    logic [31:0] data;
    logic        we;
    logic        ill;
  } obs_t;

  ent_t        q[$];
  obs_t        got[$];
  logic [31:0] exp_cnt;
  int          checks;
  int          failures;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic ent_t ref_model(input logic [31:0] ins,
                                     input logic [31:0] x,
                                     input logic [31:0] y);
    ent_t        e;
    logic [6:0]  f7;
    logic [2:0]  f3;
    logic [31:0] imm;
    logic [31:0] r;
    int          sh;
    bit          ok;
    f7  = ins[31:25];
    f3  = ins[14:12];
    imm = {{20{ins[31]}}, ins[31:20]};
    r   = 0;
    ok  = 1;
    if (ins[6:0] == 7'h33) begin
      sh = int'(y[4:0]);
      if (ins[24]) ok = 0;
      if (f7 == 7'h00) begin
        case (f3)
          0: r = x + y;
          1: r = x << sh;
          2: r = ($signed(x) < $signed(y)) ? 1 : 0;
          3: r = (x < y) ? 1 : 0;
          4: r = x ^ y;
          5: r = x >> sh;
          6: r = x | y;
          default: r = x & y;
        endcase
      end else if (f7 == 7'h20 && f3 == 0) r = x - y;
      else if (f7 == 7'h20 && f3 == 5) r = $signed(x) >>> sh;
      else ok = 0;
    end else if (ins[6:0] == 7'h13) begin
      sh = int'(ins[24:20]);
      case (f3)
        0: r = x + imm;
        2: r = ($signed(x) < $signed(imm)) ? 1 : 0;
        3: r = (x < imm) ? 1 : 0;
        4: r = x ^ imm;
        6: r = x | imm;
        7: r = x & imm;
        1: if (f7 == 7'h00) r = x << sh; else ok = 0;
        default: begin
          if (f7 == 7'h00) r = x >> sh;
          else if (f7 == 7'h20) r = $signed(x) >>> sh;
          else ok = 0;
        end
      endcase
    end else begin
      ok = 0;
    end
    if (ins[11] || ins[19]) ok = 0;
    e.rd   = ins[10:7];
    e.ill  = !ok;
    e.data = ok ? r : 32'd0;
    e.we   = ok && (ins[10:7] != 0);
    e.age  = 0;
    return e;
  endfunction

  function automatic logic [31:0] enc_r(input logic [6:0] f7, input int rs2,
                                        input int rs1, input logic [2:0] f3,
                                        input int rd);
    logic [4:0] a, b, d;
    a = rs1[4:0]; b = rs2[4:0]; d = rd[4:0];
    return {f7, b, a, f3, d, 7'h33};
  endfunction

  function automatic logic [31:0] enc_i(input int imm, input int rs1,
                                        input logic [2:0] f3, input int rd);
    logic [11:0] im;
    logic [4:0]  a, d;
    im = imm[11:0]; a = rs1[4:0]; d = rd[4:0];
    return {im, a, f3, d, 7'h13};
  endfunction

  function automatic logic [31:0] rnd_instr();
    logic [31:0] w;
    int          k;
    w = $urandom();
    k = $urandom_range(0, 9);
    if (k >= 1 && k <= 5) w[6:0] = 7'h33;
    else if (k > 5)       w[6:0] = 7'h13;
    k = $urandom_range(0, 5);
    if (k <= 2)      w[31:25] = 7'h00;
    else if (k <= 4) w[31:25] = 7'h20;
    if ($urandom_range(0, 7) != 0) begin
      w[11] = 1'b0; w[19] = 1'b0; w[24] = 1'b0;
    end
    return w;
  endfunction

  // one clock: check outputs against model, step model across the edge
  task automatic tick(output bit acc);
    bit   exp_rdy, exp_wbv, pop;
    ent_t e;
    #1;
    exp_rdy = (q.size() < 2) || wb_ready;
    exp_wbv = (q.size() > 0) && (q[0].age >= 1);
    chk("in_ready", in_ready, exp_rdy);
    chk("wb_valid", wb_valid, exp_wbv);
    chk("retired_cnt", retired_cnt, exp_cnt);
    if (exp_wbv) begin
      chk("wb_data", wb_data, q[0].data);
      chk("wb_we", wb_we, q[0].we);
      chk("wb_illegal", wb_illegal, q[0].ill);
      if (!q[0].ill) chk("wb_rd", wb_rd, q[0].rd);
    end
    if (wb_valid && wb_ready) got.push_back('{wb_data, wb_we, wb_illegal});
    acc = in_valid && exp_rdy && !flush;
    pop = exp_wbv && wb_ready;
    e   = ref_model(in_instr, in_rs1_data, in_rs2_data);
    @(posedge clk);
    #1;
    if (pop) exp_cnt++;
    if (flush) q.delete();
    else begin
      if (pop) void'(q.pop_front());
      foreach (q[i]) q[i].age++;
      if (acc) q.push_back(e);
    end
  endtask

  task automatic issue(input logic [31:0] ins, input logic [31:0] x,
                       input logic [31:0] y);
    bit acc;
    in_valid    = 1'b1;
    in_instr    = ins;
    in_rs1_data = x;
    in_rs2_data = y;
    acc = 0;
    for (int n = 0; n < 20 && !acc; n++) tick(acc);
    if (!acc) chk("accept_timeout", 0, 1);
    in_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    bit acc;
    in_valid = 1'b0;
    for (int i = 0; i < n; i++) tick(acc);
  endtask

  initial begin
    bit acc;
    int base;
    checks      = 0;
    failures    = 0;
    exp_cnt     = 0;
    rst_n       = 1'b0;
    flush       = 1'b0;
    in_valid    = 1'b0;
    in_instr    = '0;
    in_rs1_data = '0;
    in_rs2_data = '0;
    wb_ready    = 1'b1;
    #12;
    chk("rst_in_ready", in_ready, 1);
    chk("rst_alu_op", alu_op, 0);
    chk("rst_alu_a", alu_a, 0);
    chk("rst_alu_b", alu_b, 0);
    chk("rst_wb_valid", wb_valid, 0);
    chk("rst_wb_rd", wb_rd, 0);
    chk("rst_wb_we", wb_we, 0);
    chk("rst_wb_data", wb_data, 0);
    chk("rst_wb_illegal", wb_illegal, 0);
    chk("rst_cnt", retired_cnt, 0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // ADD x1,x2,x3
    base = got.size();
    issue(enc_r(7'h00, 3, 2, 3'd0, 1), 32'd10, 32'd20);
    idle(3);
    chk("add_data", got[base].data, 32'd30);
    chk("add_cnt", retired_cnt, 32'd1);

    // AND/OR/XOR back to back
    base = got.size();
    issue(enc_r(7'h00, 2, 1, 3'd7, 4), 32'h0F0F0F0F, 32'h00FF00FF);
    issue(enc_r(7'h00, 2, 1, 3'd6, 5), 32'h0F0F0F0F, 32'h00FF00FF);
    issue(enc_r(7'h00, 2, 1, 3'd4, 6), 32'h0F0F0F0F, 32'h00FF00FF);
    idle(4);
    chk("and_data", got[base].data, 32'h000F000F);
    chk("or_data", got[base+1].data, 32'h0FFF0FFF);
    chk("xor_data", got[base+2].data, 32'h0FF00FF0);

    // SUB then SRAI x5,x6,4
    base = got.size();
    issue(enc_r(7'h20, 2, 1, 3'd0, 3), 32'd30, 32'd10);
    issue(enc_i(32'h404, 6, 3'd5, 5), 32'hF0000000, 32'd0);
    idle(4);
    chk("sub_data", got[base].data, 32'd20);
    chk("srai_data", got[base+1].data, 32'hFF000000);

    // backpressure with three instructions
    base = got.size();
    wb_ready = 1'b0;
    in_valid = 1'b1;
    in_instr = enc_i(1, 1, 3'd0, 7); in_rs1_data = 32'd100;
    tick(acc);
    in_instr = enc_i(2, 1, 3'd0, 8); in_rs1_data = 32'd200;
    tick(acc);
    in_instr = enc_i(3, 1, 3'd0, 9); in_rs1_data = 32'd300;
    tick(acc);
    tick(acc);
    tick(acc);
    chk("stall_in_ready", in_ready, 0);
    wb_ready = 1'b1;
    tick(acc);
    chk("stall_third_acc", acc, 1);
    idle(5);
    chk("stall_count", got.size() - base, 3);
    chk("stall_d0", got[base].data, 32'd101);
    chk("stall_d1", got[base+1].data, 32'd202);
    chk("stall_d2", got[base+2].data, 32'd303);

    // illegal encodings and ADDI x0
    base = got.size();
    issue(enc_r(7'h00, 2, 1, 3'd0, 17), 32'd5, 32'd6);
    issue(enc_r(7'h20, 2, 1, 3'd4, 3), 32'd5, 32'd6);
    issue(enc_i(5, 0, 3'd0, 0), 32'd0, 32'd0);
    idle(4);
    chk("ill0_flag", got[base].ill, 1);
    chk("ill0_data", got[base].data, 0);
    chk("ill1_flag", got[base+1].ill, 1);
    chk("ill1_we", got[base+1].we, 0);
    chk("addi_x0_we", got[base+2].we, 0);
    chk("addi_x0_data", got[base+2].data, 32'd5);

    // flush with both stages full and input pending
    wb_ready = 1'b0;
    issue(enc_i(1, 1, 3'd0, 2), 32'd1, 32'd0);
    issue(enc_i(2, 1, 3'd0, 2), 32'd1, 32'd0);
    idle(1);
    base = int'(retired_cnt);
    in_valid = 1'b1;
    in_instr = enc_i(3, 1, 3'd0, 2);
    flush = 1'b1;
    tick(acc);
    flush = 1'b0;
    in_valid = 1'b0;
    chk("flush_wb_valid", wb_valid, 0);
    chk("flush_in_ready", in_ready, 1);
    chk("flush_cnt", retired_cnt, base);
    wb_ready = 1'b1;
    idle(3);

    // asynchronous reset mid-operation
    wb_ready = 1'b0;
    issue(enc_i(9, 1, 3'd0, 3), 32'd1, 32'd0);
    issue(enc_i(9, 1, 3'd0, 3), 32'd1, 32'd0);
    rst_n = 1'b0;
    #2;
    chk("arst_wb_valid", wb_valid, 0);
    chk("arst_in_ready", in_ready, 1);
    chk("arst_cnt", retired_cnt, 0);
    q.delete();
    exp_cnt = 0;
    rst_n = 1'b1;
    wb_ready = 1'b1;
    @(posedge clk);
    #1;

    // random traffic
    for (int i = 0; i < 600; i++) begin
      in_valid    = ($urandom_range(0, 3) != 0);
      wb_ready    = ($urandom_range(0, 3) != 0);
      flush       = ($urandom_range(0, 31) == 0);
      in_instr    = rnd_instr();
      in_rs1_data = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 8)) : $urandom();
      in_rs2_data = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 8)) : $urandom();
      tick(acc);
    end
    flush = 1'b0;
    wb_ready = 1'b1;
    idle(4);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
